uart_tx_fifo: RTL and testbench

//  Parametrised successor to the fixed 8N1 UART transmitter. Bytes are written into an internal

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_tx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the parametrised UART transmitter and its receiver twin:
// parity mode encodings and the serializer FSM state type.
package uart_tx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
// Writes while full are ignored even if a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, which keeps the array a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: configurable data width, parity and stop bits.
// Frames are sent back-to-back; all line-side outputs are registered.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_DV,
  input  logic [DATA_BITS-1:0]        i_Byte,
  output logic                        o_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Overflow,
  output logic                        o_Serial_Data,
  output logic                        o_Sig_Active,
  output logic                        o_Sig_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_e            state;
  tx_state_e            state_next;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shifter;
  logic                 bit_end;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;

  logic                 line_d;
  logic                 active_d;
  logic                 done_d;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign o_Ready  = !fifo_full;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (i_DV),
    .pop  (fifo_pop),
    .wdata(i_Byte),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(o_Fifo_Count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (!fifo_empty) state_next = ST_START;
      ST_START:   if (bit_end) state_next = ST_DATA;
      ST_DATA:    if (bit_end && bit_idx == DATA_LAST)
                    state_next = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY:  if (bit_end) state_next = ST_STOP;
      ST_STOP:    if (bit_end && bit_idx == STOP_LAST) state_next = ST_CLEANUP;
      ST_CLEANUP: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; it clears on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      if (state == ST_IDLE || state == ST_CLEANUP || bit_end) baud_cnt <= '0;
      else                                                    baud_cnt <= baud_cnt + 1'b1;

      if (fifo_pop) shifter <= fifo_rdata;

      if (state_next != state)
        bit_idx <= '0;
      else if (bit_end && (state == ST_DATA || state == ST_STOP))
        bit_idx <= bit_idx + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    line_d   = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    unique case (state)
      ST_START:   begin line_d = 1'b0;             active_d = 1'b1; end
      ST_DATA:    begin line_d = shifter[bit_idx]; active_d = 1'b1; end
      ST_PARITY:  begin
        line_d   = (PARITY_MODE == PARITY_ODD) ? ~^shifter : ^shifter;
        active_d = 1'b1;
      end
      ST_STOP:    active_d = 1'b1;
      ST_CLEANUP: done_d   = 1'b1;
      default:    ;
    endcase
  end

  // Registering the decoded state gives a glitch-free line one cycle behind the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_Serial_Data <= 1'b1;
      o_Sig_Active  <= 1'b0;
      o_Sig_Done    <= 1'b0;
      o_Overflow    <= 1'b0;
    end else begin
      o_Serial_Data <= line_d;
      o_Sig_Active  <= active_d;
      o_Sig_Done    <= done_d;
      o_Overflow    <= i_DV && fifo_full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations, a frame-stream model for the 8N1 instance
// checked every cycle, and hand-computed frame images for the directed cases.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] dv = '0;
  logic [8:0] wbyte = '0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic       ready  [5];
  logic       ovf    [5];
  logic       line   [5];
  logic       active [5];
  logic       done   [5];
  logic [3:0] cnt    [5];
  int         done_cnt [5] = '{default: 0};
  int         ovf_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2, 4: 8N1 at 87 clocks per bit
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .i_DV(dv[0]), .i_Byte(wbyte[7:0]), .o_Ready(ready[0]), .o_Fifo_Count(cnt[0]),
    .o_Overflow(ovf[0]), .o_Serial_Data(line[0]), .o_Sig_Active(active[0]), .o_Sig_Done(done[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_e (
    .clk(clk), .rst(rst), .i_DV(dv[1]), .i_Byte(wbyte[7:0]), .o_Ready(ready[1]), .o_Fifo_Count(cnt[1]),
    .o_Overflow(ovf[1]), .o_Serial_Data(line[1]), .o_Sig_Active(active[1]), .o_Sig_Done(done[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u_o (
    .clk(clk), .rst(rst), .i_DV(dv[2]), .i_Byte(wbyte[7:0]), .o_Ready(ready[2]), .o_Fifo_Count(cnt[2]),
    .o_Overflow(ovf[2]), .o_Serial_Data(line[2]), .o_Sig_Active(active[2]), .o_Sig_Done(done[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_s (
    .clk(clk), .rst(rst), .i_DV(dv[3]), .i_Byte(wbyte[6:0]), .o_Ready(ready[3]), .o_Fifo_Count(cnt[3]),
    .o_Overflow(ovf[3]), .o_Serial_Data(line[3]), .o_Sig_Active(active[3]), .o_Sig_Done(done[3]));
  uart_tx_fifo #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_l (
    .clk(clk), .rst(rst), .i_DV(dv[4]), .i_Byte(wbyte[7:0]), .o_Ready(ready[4]), .o_Fifo_Count(cnt[4]),
    .o_Overflow(ovf[4]), .o_Serial_Data(line[4]), .o_Sig_Active(active[4]), .o_Sig_Done(done[4]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) if (done[i] === 1'b1) done_cnt[i]++;
    if (ovf[0] === 1'b1) ovf_cnt++;
  end

  // Model of the 8N1 instance: a word queue plus a per-cycle stream of expected line slots.
  // A frame is queued as soon as the stream runs dry; each frame is followed by a Done slot
  // and one idle slot, which yields the two-cycle gap and the two-cycle start latency.
  typedef struct packed { logic line; logic act; logic done; } slot_t;
  localparam slot_t IDLE_SLOT = '{line: 1'b1, act: 1'b0, done: 1'b0};
  slot_t      slots [$];
  logic [7:0] words [$];
  slot_t      exp_slot = IDLE_SLOT;
  logic       exp_ovf = 1'b0;

  always @(posedge clk) begin : model
    logic       full_before;
    logic [7:0] w;
    logic       b;
    if (rst) begin
      slots.delete();
      words.delete();
      exp_slot = IDLE_SLOT;
      exp_ovf  = 1'b0;
    end else begin
      full_before = (words.size() == 8);
      if (slots.size() > 0) exp_slot = slots.pop_front();
      else                  exp_slot = IDLE_SLOT;
      if (slots.size() == 0 && words.size() > 0) begin
        w = words.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k == 0)      b = 1'b0;
          else if (k == 9) b = 1'b1;
          else             b = w[k-1];
          for (int c = 0; c < CPB; c++) slots.push_back('{line: b, act: 1'b1, done: 1'b0});
        end
        slots.push_back('{line: 1'b1, act: 1'b0, done: 1'b1});
        slots.push_back(IDLE_SLOT);
      end
      exp_ovf = dv[0] && full_before;
      if (dv[0] && !full_before) words.push_back(wbyte[7:0]);
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("model_line",   line[0],   exp_slot.line);
      check("model_active", active[0], exp_slot.act);
      check("model_done",   done[0],   exp_slot.done);
      check("model_count",  cnt[0],    words.size());
      check("model_ready",  ready[0],  words.size() < 8);
      check("model_ovf",    ovf[0],    exp_ovf);
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input int which, input logic [8:0] b);
    dv[which] = 1'b1;
    wbyte     = b;
    @(posedge clk);
    #1;
    dv[which] = 1'b0;
  endtask

  // Finds the start bit, then samples each bit in its third cycle and tracks Active/Done.
  task automatic capture(input int which, input int nbits, input int w_edge,
                         output logic [15:0] bits, output int act_cnt, output int done_off);
    int s_edge = -1;
    bits = '0;
    act_cnt = 0;
    done_off = -1;
    for (int i = 0; i < 60 && s_edge < 0; i++) begin
      @(negedge clk);
      if (line[which] === 1'b0) s_edge = cyc;
    end
    check("start_latency", s_edge - w_edge, 2);
    if (s_edge >= 0) begin
      for (int j = 0; j <= nbits * CPB + 2; j++) begin
        if (j > 0) @(negedge clk);
        if (j % CPB == 2 && j / CPB < nbits) bits[j / CPB] = line[which];
        if (active[which] === 1'b1) act_cnt++;
        if (done[which] === 1'b1 && done_off < 0) done_off = j;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  rx;
    int          ac, doff, w, d0, o0, s;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_line",   line[0],   1'b1);
    check("rst_active", active[0], 1'b0);
    check("rst_done",   done[0],   1'b0);
    check("rst_count",  cnt[0],    4'd0);
    check("rst_ready",  ready[0],  1'b1);
    check("rst_ovf",    ovf[0],    1'b0);
    for (int i = 1; i < 5; i++) check("rst_line_cfg", line[i], 1'b1);

    // 8N1, 0x64: 0 | 0,0,1,0,0,1,1,0 | 1
    d0 = done_cnt[0];
    send(0, 9'h064);
    w = cyc;
    capture(0, 10, w, bits, ac, doff);
    check("8n1_frame",  bits[9:0], 10'h2C8);
    check("8n1_active", ac, 40);
    check("8n1_done",   doff, 40);
    check("8n1_done_n", done_cnt[0] - d0, 1);

    // Even and odd parity on 0x64 (three ones): parity bit 1 and 0
    send(1, 9'h064);
    w = cyc;
    capture(1, 11, w, bits, ac, doff);
    check("8e1_frame", bits[10:0], 11'h6C8);
    check("8e1_done",  doff, 44);
    send(2, 9'h064);
    w = cyc;
    capture(2, 11, w, bits, ac, doff);
    check("8o1_frame", bits[10:0], 11'h4C8);
    check("8o1_done",  doff, 44);

    // 7N2, 0x55: 0 | 1,0,1,0,1,0,1 | 1,1
    send(3, 9'h055);
    w = cyc;
    capture(3, 10, w, bits, ac, doff);
    check("7n2_frame",  bits[9:0], 10'h3AA);
    check("7n2_active", ac, 40);
    check("7n2_done",   doff, 40);

    // Burst of 10 writes into depth 8: one popped, eight queued, one dropped
    d0 = done_cnt[0];
    o0 = ovf_cnt;
    for (int i = 0; i < 10; i++) send(0, 9'(16 + i));
    check("burst_count", cnt[0],   4'd8);
    check("burst_ready", ready[0], 1'b0);
    check("burst_ovf",   ovf[0],   1'b1);
    for (int k = 0; k < 9 * 44 + 60 && done_cnt[0] - d0 < 9; k++) @(posedge clk);
    #1;
    check("burst_frames", done_cnt[0] - d0, 9);
    check("burst_ovf_n",  ovf_cnt - o0, 1);
    check("burst_empty",  cnt[0], 4'd0);

    // Reset in the middle of DATA with three words queued
    for (int i = 0; i < 4; i++) send(0, 9'(8'h31 + i));
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst_active", active[0], 1'b1);
    check("pre_rst_count",  cnt[0],    4'd3);
    d0 = done_cnt[0];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_line",   line[0],   1'b1);
    check("abort_count",  cnt[0],    4'd0);
    check("abort_active", active[0], 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt[0] - d0, 0);
    check("abort_idle",    line[0], 1'b1);
    send(0, 9'h0A5);
    w = cyc;
    capture(0, 10, w, bits, ac, doff);
    check("post_rst_frame", bits[9:0], 10'h34A);
    check("post_rst_done",  doff, 40);

    // 87 clocks per bit, 8N1, decimal 100 decoded by a mid-bit sampling receiver
    d0 = done_cnt[4];
    send(4, 9'd100);
    w = cyc;
    s = -1;
    for (int i = 0; i < 300 && s < 0; i++) begin
      @(negedge clk);
      if (line[4] === 1'b0) s = cyc;
    end
    check("lb_latency", s - w, 2);
    if (s >= 0) begin
      repeat (43) @(negedge clk);
      check("lb_start_mid", line[4], 1'b0);
      rx = '0;
      for (int b = 0; b < 8; b++) begin
        repeat (87) @(negedge clk);
        rx[b] = line[4];
      end
      repeat (87) @(negedge clk);
      check("lb_stop", line[4], 1'b1);
      check("lb_byte", rx, 8'd100);
      repeat (60) @(negedge clk);
      check("lb_done", done_cnt[4] - d0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
